// File: rtl/rf_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Register-file write-port arbiter between the pipeline
//               writeback stage and a long-latency unit (LLU). LLU results
//               queue in a 2-entry FIFO; a starvation counter can freeze the
//               pipeline writeback so the FIFO head is drained. A pending-write
//               scoreboard reports RAW hazards on outstanding LLU destinations.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        llu_valid,
  input  logic [4:0]  llu_rd,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        hazard,
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
  localparam logic [3:0] c_starve_max   = 4'hF;

  // Registered state
  logic        r_alive;          // set on the first edge after reset release
  logic [1:0]  r_occ;
  logic        r_rptr;
  logic        r_wptr;
  logic [4:0]  r_frd   [2];
  logic [31:0] r_fdata [2];
  logic [3:0]  r_starve;
  logic        r_stall;
  logic [31:0] r_pending;

  // Combinational decode
  logic        w_fifo_ne;
  logic        w_llu_ready;
  logic        w_push;
  logic        w_wb_live;
  logic        w_grant_wb;
  logic        w_grant_fifo;
  logic [4:0]  w_head_rd;
  logic [31:0] w_head_data;
  logic [3:0]  w_starve_next;
  logic [31:0] w_pending_next;

  assign w_fifo_ne   = (r_occ != 2'd0);
  assign w_llu_ready = r_alive && (r_occ < 2'd2);
  assign w_push      = llu_valid && w_llu_ready && (llu_rd != 5'd0);
  assign w_wb_live   = wb_we && (wb_rd != 5'd0);
  assign w_head_rd   = r_frd[r_rptr];
  assign w_head_data = r_fdata[r_rptr];

  // Grants are forced off while reset is held so the write port is quiet
  assign w_grant_wb   = rst && !r_stall && w_wb_live;
  assign w_grant_fifo = rst && !w_grant_wb && w_fifo_ne;

  // Write-port mux: granted source drives the register file this cycle
  always_comb begin
    RegWriteW = 1'b0;
    RdW       = 5'd0;
    ResultW   = 32'd0;
    if (w_grant_wb) begin
      RegWriteW = 1'b1;
      RdW       = wb_rd;
      ResultW   = wb_data;
    end else if (w_grant_fifo) begin
      RegWriteW = 1'b1;
      RdW       = w_head_rd;
      ResultW   = w_head_data;
    end
  end

  // Starvation count: advances only while the head waits, saturating at max
  always_comb begin
    w_starve_next = 4'd0;
    if (w_fifo_ne && !w_grant_fifo) begin
      w_starve_next = (r_starve != c_starve_max) ? (r_starve + 4'd1) : r_starve;
    end
  end

  // Scoreboard next state: clear the drained destination, then set wins
  always_comb begin
    w_pending_next = r_pending;
    if (w_grant_fifo) begin
      w_pending_next[w_head_rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      w_pending_next[iss_rd] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  // LLU result FIFO: occupancy, pointers and storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alive    <= 1'b0;
      r_occ      <= 2'd0;
      r_rptr     <= 1'b0;
      r_wptr     <= 1'b0;
      r_frd[0]   <= 5'd0;
      r_frd[1]   <= 5'd0;
      r_fdata[0] <= 32'd0;
      r_fdata[1] <= 32'd0;
    end else begin
      r_alive <= 1'b1;
      if (w_push) begin
        r_frd[r_wptr]   <= llu_rd;
        r_fdata[r_wptr] <= llu_data;
        r_wptr          <= ~r_wptr;
      end
      if (w_grant_fifo) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_grant_fifo})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Starvation counter and registered writeback freeze
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= 4'd0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_next;
      if (w_grant_fifo) begin
        r_stall <= 1'b0;
      end else if (w_fifo_ne && (w_starve_next == c_starve_limit)) begin
        r_stall <= 1'b1;
      end
    end
  end

  // Pending-write scoreboard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  assign llu_ready = w_llu_ready;
  assign wb_stall  = r_stall;
  assign hazard    = r_pending[chk_rs1] | r_pending[chk_rs2];

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles the LLU FIFO head may wait ungranted before wb_stall asserts (legal range 1..15).
REQ-002 SHALL have port clk  in  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port wb_we  in  1  pipeline writeback request.
REQ-005 SHALL have port wb_rd  in  5  pipeline destination register.
REQ-006 SHALL have port wb_data  in  32  pipeline writeback data.
REQ-007 SHALL have port wb_stall  out  1  freeze pipeline writeback; the pipeline holds wb_we/wb_rd/wb_data stable while it is high.
REQ-008 SHALL have port llu_valid  in  1  long-latency-unit result valid.
REQ-009 SHALL have port llu_rd  in  5  LLU destination register.
REQ-010 SHALL have port llu_data  in  32  LLU result data.
REQ-011 SHALL have port llu_ready  out  1  arbiter can accept an LLU result.
REQ-012 SHALL have port iss_valid  in  1  an LLU operation issues this cycle.
REQ-013 SHALL have port iss_rd  in  5  destination of the issuing LLU operation.
REQ-014 SHALL have port chk_rs1  in  5  source register 1 to hazard-check.
REQ-015 SHALL have port chk_rs2  in  5  source register 2 to hazard-check.
REQ-016 SHALL have port hazard  out  1  a checked source has an outstanding LLU write.
REQ-017 SHALL have port RegWriteW  out  1  register-file write enable.
REQ-018 SHALL have port RdW  out  5  register-file write address.
REQ-019 SHALL have port ResultW  out  32  register-file write data.

Function
REQ-020 SHALL hold accepted LLU results in a 2-entry FIFO; llu_ready = (occupancy < 2), derived from registered occupancy only.
REQ-021 SHALL accept an LLU result on a clk edge where llu_valid && llu_ready; if llu_rd == 0 the handshake completes but nothing is stored.
REQ-022 SHALL treat a WB request as live only when wb_we && wb_rd != 0; wb_rd == 0 requests never reach the write port.
REQ-023 SHALL grant the write port combinationally each cycle: if wb_stall == 0 and WB is live, grant WB; otherwise, if the FIFO is non-empty, grant the FIFO head; otherwise, no grant.
REQ-024 SHALL drive RegWriteW/RdW/ResultW from the granted source in the same cycle; with no grant, RegWriteW = 0, RdW = 0, ResultW = 0.
REQ-025 SHALL pop the FIFO head on the edge it is granted; a push and a pop on the same edge leave occupancy unchanged and preserve order.
REQ-026 SHALL keep a 4-bit starvation counter: it increments on each edge where the FIFO is non-empty and the head is not granted, and clears on a pop or while the FIFO is empty.
REQ-027 SHALL register wb_stall = 1 on the edge where the counter reaches STARVE_LIMIT, and clear it on the edge after the next FIFO pop.
REQ-028 SHALL, while wb_stall == 1, grant the FIFO head regardless of WB.
REQ-029 SHALL keep a 32-bit pending scoreboard: set bit iss_rd on iss_valid when iss_rd != 0; clear bit RdW on an edge where the FIFO head is granted.
REQ-030 SHALL let set win when set and clear of the same bit coincide.
REQ-031 SHALL keep bit 0 of the scoreboard permanently 0.
REQ-032 SHALL compute hazard = pending[chk_rs1] | pending[chk_rs2] combinationally from registered scoreboard state.

Reset
REQ-033 SHALL, while rst == 0, asynchronously clear FIFO occupancy, FIFO storage, scoreboard, starvation counter and wb_stall.
REQ-034 SHALL produce these outputs while rst == 0: llu_ready = 0, hazard = 0, RegWriteW = 0, RdW = 0, ResultW = 0, wb_stall = 0.
REQ-035 SHALL raise llu_ready to 1 in the first cycle after rst deasserts; results in flight when reset asserts are discarded.

Verification
REQ-036 SHALL pass: wb_we=1, wb_rd=5, wb_data=0xA5, FIFO empty -> same cycle RegWriteW=1, RdW=5, ResultW=0xA5.
REQ-037 SHALL pass: wb_we=1, wb_rd=0, FIFO holds (rd=3, 0x77) -> FIFO granted, RdW=3, ResultW=0x77, occupancy 1->0.
REQ-038 SHALL pass: WB live every cycle, one LLU push (rd=7) -> wb_stall=1 after 4 waiting edges; next cycle RdW=7; wb_stall=0 the following cycle; held WB then written.
REQ-039 SHALL pass: three back-to-back llu_valid with WB live -> llu_ready=0 after 2 accepts; third value accepted only after a pop, with FIFO order preserved.
REQ-040 SHALL pass: iss_valid with iss_rd=9, then chk_rs1=9 -> hazard=1 until the LLU rd=9 write is granted, then 0; iss_rd=0 -> hazard stays 0.
REQ-041 SHALL pass: rst pulled low with FIFO full, wb_stall=1 and pending bits set -> all outputs 0 immediately; llu_ready=1 one cycle after release.
